fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 37 +++
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch unit, its buffer and the decoder.
//   - FSM state encodings (plain localparams so legacy tools can read them)
//   - NOP instruction used as the reset/empty buffer contents
//   - RV32I major opcode constants shared with the decoder
//   - small address helpers for redirect-target handling
// Optional build macro: FETCH_MISALIGN_CHECK_EN (used by fetch_unit).
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [2:0] ST_REQ  = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  // Clear the byte-offset bits so the address points at a whole word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: single-entry instruction/PC holding register.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   load              capture load_instr/load_pc and mark the entry valid
//   flush             invalidate the entry (consumed or squashed)
//   load_instr/load_pc  incoming instruction word and its address
//   valid             entry holds an instruction for decode
//   instr/instr_pc    buffered instruction and its address
//   opcode/funct3/funct7  fields decoded straight from the buffer register
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Load wins over flush; the controller never asks for both at once, but
  // a fresh word must never be lost to a stale invalidate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc_q    <= RESET_PC;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= load_instr;
      pc_q    <= load_pc;
    end else if (flush) begin
      valid_q <= 1'b0;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign instr_pc = pc_q;
  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[30];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch controller with one outstanding request.
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data           response channel from instruction memory
//   instr_valid/instr_ready       buffered instruction handshake to decode
//   instr, instr_pc               buffered instruction and its address
//   opcode, funct3, funct7        fields of the buffered instruction
//   redirect, redirect_target     taken-branch PC override
//   misalign_err                  sticky misaligned-redirect flag
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds an ERR state entered on
// a misaligned redirect; without it redirect targets are word-aligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misalign_err
);

  logic [2:0]  state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] target;
  logic        buf_load, buf_flush;
  logic        err_set;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic redirect_bad;
  assign target       = redirect_target;
  assign redirect_bad = redirect && !is_word_aligned(redirect_target);
`else
  assign target = align_word(redirect_target);
`endif

  // Next-state and PC logic. A redirect always beats normal progress; in WAIT
  // and DROP it decides whether an in-flight response still has to be eaten.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_REQ: begin
        if (redirect) begin
          pc_next = target;
        end else if (imem_req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_next    = target;
          state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          buf_load   = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_next    = target;
          buf_flush  = 1'b1;
          state_next = ST_REQ;
        end else if (instr_ready) begin
          buf_flush  = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          pc_next = target;
        end
        if (imem_rsp_valid) begin
          state_next = ST_REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_ERR: begin
        state_next = ST_ERR;
      end
`endif
      default: begin
        state_next = ST_REQ;
      end
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    // A bad target freezes fetch entirely until reset.
    if (redirect_bad && state != ST_ERR) begin
      state_next = ST_ERR;
      pc_next    = pc;
      buf_load   = 1'b0;
      buf_flush  = 1'b1;
      err_set    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (err_set) begin
      misalign_q <= 1'b1;
    end
  end
  assign misalign_err = misalign_q;
`else
  assign misalign_err = err_set;
`endif

  // The request is gated by reset so nothing is presented while held in reset,
  // yet it appears immediately once reset is released.
  assign imem_req_valid = (state == ST_REQ) && !reset;
  assign imem_req_addr  = pc;

  fetch_buffer #(
    .RESET_PC(RESET_PC)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .flush     (buf_flush),
    .load_instr(imem_rsp_data),
    .load_pc   (pc),
    .valid     (instr_valid),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Honours FETCH_MISALIGN_CHECK_EN in the same way as the design.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Count completed decode handshakes as the consumer would see them.
  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready) hs_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, clock once, then return inputs to idle.
  task automatic applyStimulus(input logic rq_ready, input logic rsp_v,
                               input logic [31:0] rsp_d, input logic in_ready,
                               input logic redir, input logic [31:0] tgt);
    imem_req_ready  = rq_ready;
    imem_rsp_valid  = rsp_v;
    imem_rsp_data   = rsp_d;
    instr_ready     = in_ready;
    redirect        = redir;
    redirect_target = tgt;
    tick();
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
  endtask

  // One full fetch: accept, response one cycle later, consume.
  task automatic fetchOne(input logic [31:0] addr, input logic [31:0] data,
                          input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7);
    checkOutput("req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("req_addr", imem_req_addr, addr);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("req_valid_after_accept", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0);
    checkOutput("instr_valid", 32'(instr_valid), 32'd1);
    checkOutput("instr", instr, data);
    checkOutput("instr_pc", instr_pc, addr);
    checkOutput("opcode", 32'(opcode), 32'(opc));
    checkOutput("funct3", 32'(funct3), 32'(f3));
    checkOutput("funct7", 32'(funct7), 32'(f7));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("instr_valid_consumed", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("post_rst_req_addr", imem_req_addr, 32'h0);

    // Sequential fetch, with a three-cycle ready stall before the 0x4 accept
    fetchOne(32'h0, 32'h0050_0093, OPC_OP_IMM, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("stall_req_addr", imem_req_addr, 32'h4);
    end
    fetchOne(32'h4, 32'h4020_8133, OPC_OP, 3'd0, 1'b1);
    fetchOne(32'h8, 32'h0000_a183, OPC_LOAD, 3'd2, 1'b0);
    checkOutput("hs_after_three", 32'(hs_count), 32'd3);

    // Response while in REQ is ignored
    applyStimulus(1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0, 32'h0);
    checkOutput("stray_rsp_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("stray_rsp_addr", imem_req_addr, 32'hC);

    // Redirect in WAIT, response arrives two cycles later and is dropped
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    checkOutput("drop_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("drop_wait_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    checkOutput("drop_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("drop_next_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("drop_next_addr", imem_req_addr, 32'h100);

    // Redirect coincident with response: data discarded
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h200);
    checkOutput("coinc_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("coinc_instr_kept", instr, 32'h0000_a183);
    checkOutput("coinc_next_addr", imem_req_addr, 32'h200);
    checkOutput("coinc_next_valid", 32'(imem_req_valid), 32'd1);

    // Redirect in HOLD without instr_ready: buffer flushed
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_valid", 32'(instr_valid), 32'd1);
    checkOutput("hold_pc", instr_pc, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    checkOutput("flush_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("flush_next_addr", imem_req_addr, 32'h40);
    checkOutput("flush_hs", 32'(hs_count), 32'd3);

    // Redirect in HOLD with instr_ready: handshake counted once
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0020_0193, 1'b0, 1'b0, 32'h0);
    checkOutput("hold2_pc", instr_pc, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    checkOutput("hs_redirect_valid", 32'(instr_valid), 32'd0);
    checkOutput("hs_redirect_addr", imem_req_addr, 32'h40);
    checkOutput("hs_redirect_count", 32'(hs_count), 32'd4);

    // Misaligned redirect
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("mis_err", 32'(misalign_err), 32'd1);
    checkOutput("mis_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h300);
    checkOutput("mis_err_sticky", 32'(misalign_err), 32'd1);
    checkOutput("mis_req_stays_off", 32'(imem_req_valid), 32'd0);
    checkOutput("mis_instr_valid", 32'(instr_valid), 32'd0);
`else
    checkOutput("mis_err", 32'(misalign_err), 32'd0);
    checkOutput("mis_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("mis_aligned_addr", imem_req_addr, 32'h100);
`endif

    // Reset mid-transaction, late response ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("midrst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b0;
    #1;
    applyStimulus(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    checkOutput("late_rsp_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("late_rsp_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("late_rsp_addr", imem_req_addr, 32'h0);
    checkOutput("late_rsp_instr", instr, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
